edge_event_arbiter: RTL
=======================

// Module: edge_event_arbiter
// PURPOSE
//   Detects rising edges on NUM_CH synchronous input lines and latches each one as a pending event.
//   Serialises pending events onto one valid/ready event port, granting channels round-robin.
//   Sits between the rise-edge trigger sources and a single event consumer (e.g. an IRQ/command sequencer).
//   Edges that arrive while their channel is already pending are flagged as overflow.
// PARAMETERS
//   NUM_CH  4  number of input channels (2..16)
//   CH_W    2  channel-id width; must equal $clog2(NUM_CH)
// PORTS
//   clk          input   1        single clock, rising edge
//   rst_n        input   1        asynchronous active-low reset
//   signal_i     input   NUM_CH   trigger lines; already synchronous to clk
//   evt_valid_o  output  1        event offered
//   evt_id_o     output  CH_W     channel id of offered event
//   evt_ready_i  input   1        consumer accepts; handshake = evt_valid_o & evt_ready_i
//   pending_o    output  NUM_CH   per-channel pending flags
//   overflow_o   output  NUM_CH   sticky per-channel lost-edge flags
//   clear_ovf_i  input   1        1-cycle pulse; clears all overflow flags
// BEHAVIOUR
//   Reset (async, immediate): prev=0, pending=0, overflow=0, evt_valid_o=0, evt_id_o=0,
//     last_grant=NUM_CH-1 (channel 0 highest priority first); FSM=IDLE; in-flight events discarded.
//   Edge: edge[i] = signal_i[i] & ~prev[i]; prev[i] <= signal_i[i] every cycle.
//     A line that is high when reset releases counts as one rising edge. A held-high level gives exactly one edge.
//   Pending update per channel, every clock:
//     acc[i] = handshake & (evt_id_o==i)
//     edge & !pending           -> pending<=1
//     edge & pending & acc      -> pending stays 1 (new event, no overflow)
//     edge & pending & !acc     -> pending stays 1, overflow<=1 (events merge)
//     !edge & acc               -> pending<=0
//   Overflow: sticky; clear_ovf_i clears all flags; a same-cycle set on a channel wins over clear.
//   FSM (2 states, registered outputs):
//     IDLE : evt_valid_o=0. If any pending -> pick, evt_id_o<=pick, evt_valid_o<=1, go OFFER.
//     OFFER: evt_valid_o=1; evt_id_o held stable until handshake; valid never drops without handshake.
//       On handshake: last_grant<=evt_id_o. Next-state pending (per the table above) nonzero ->
//       pick again with the pointer at evt_id_o+1, stay OFFER (back-to-back, 1 event/cycle). Otherwise -> IDLE, valid<=0.
//   Pick: first set bit of the request vector searching upward from (last_grant+1) mod NUM_CH, wrapping.
//     In OFFER the request vector is next-state pending, so the accepted channel has lowest priority.
//   Latency: edge sampled at clk k -> pending_o set after k -> evt_valid_o after k+1 (FSM in IDLE).
//   Fairness: any pending channel is granted within NUM_CH handshakes.
//   pending_o / overflow_o are the state registers, driven directly.
// STRUCTURE
//   Shared package edge_evt_pkg: FSM state encodings ST_IDLE/ST_OFFER; the CH_W = $clog2(NUM_CH) check.
//   Sub-module rr_pick (combinational): inputs req[NUM_CH] and ptr[CH_W]; outputs any and id[CH_W].
//     Instantiated once.
//   Edge detect, pending/overflow registers and FSM live in edge_event_arbiter.
// TESTING
//   1 Single: ch2 rises before clk k, ready=1.
//     -> pending_o=4'b0100 after k; valid=1, id=2 after k+1; pending_o=0 and valid=0 after k+2.
//   2 Burst: all 4 lines high at reset release, ready=1.
//     -> ids 0,1,2,3 on 4 consecutive cycles; no overflow; then IDLE.
//   3 Backpressure: ready=0 while ch1 is offered; ch1 goes low then high.
//     -> overflow_o[1]=1; valid=1, id=1 held. Raise ready -> exactly one ch1 event.
//     clear_ovf_i -> overflow_o=0.
//   4 Fairness: ch0 re-edges every 2 cycles, ch3 edges once, ready=1.
//     -> ch3 granted within 4 handshakes; grants alternate 0/3 while both pending.
//   5 Coincident: ch0 edge in the same cycle ch0 is accepted.
//     -> pending_o[0] stays 1, overflow_o[0]=0, ch0 re-offered later.
//     A level held 20 cycles -> exactly one event.
//   6 Reset mid-OFFER: rst_n low asynchronously -> all outputs 0 before the next clk.
//     Line held high through release -> exactly one event afterwards.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared types for the edge event arbiter.
// FSM encodings and configuration check.
package edge_evt_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  function automatic bit ch_w_ok(int num_ch, int ch_w);
    return (num_ch >= 2) && (num_ch <= 16) &&
           (ch_w == $clog2(num_ch));
  endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Round-robin picker: first set request bit
// at or above ptr, wrapping around.
module rr_pick
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              any,
  output logic [CH_W-1:0]   id
);

  int j;

  // Scan upward from ptr, keep the first hit.
  always_comb begin
    any = 1'b0;
    id  = '0;
    j   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!any && req[j[CH_W-1:0]]) begin
        any = 1'b1;
        id  = j[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event latch with round-robin
// serialisation onto one valid/ready port.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] signal_i,
  output logic              evt_valid_o,
  output logic [CH_W-1:0]   evt_id_o,
  input  logic              evt_ready_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] overflow_o,
  input  logic              clear_ovf_i
);

  if (!ch_w_ok(NUM_CH, CH_W)) begin : g_bad_cfg
    $error("edge_event_arbiter: CH_W must be $clog2(NUM_CH)");
  end

  state_t state_q;
  state_t state_d;

  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] edge_s;
  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] ovf_d;
  logic [NUM_CH-1:0] req;

  logic [CH_W-1:0] lg_q;
  logic [CH_W-1:0] lg_d;
  logic [CH_W-1:0] id_d;
  logic [CH_W-1:0] base;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] pick_id;

  logic valid_d;
  logic pick_any;
  logic hs;

  assign hs     = evt_valid_o & evt_ready_i;
  assign edge_s = signal_i & ~prev_q;
  assign acc    = hs ? (NUM_CH'(1) << evt_id_o) : '0;

  // A new edge always (re)arms; acceptance clears only without one.
  assign pend_d = edge_s | (pend_q & ~acc);
  assign ovf_d  = (clear_ovf_i ? '0 : ovf_q) |
                  (edge_s & pend_q & ~acc);

  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

  // While offering, re-arbitrate over the post-accept pending set
  // so the channel just served drops to lowest priority.
  assign req  = (state_q == ST_OFFER) ? pend_d : pend_q;
  assign base = (state_q == ST_OFFER) ? evt_id_o : lg_q;
  assign ptr  = (base == CH_W'(NUM_CH - 1)) ? '0 : base + CH_W'(1);

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .id  (pick_id)
  );

  // Previous-level register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= signal_i;
  end

  // Pending and sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // FSM state and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      lg_q        <= CH_W'(NUM_CH - 1);
    end else begin
      state_q     <= state_d;
      evt_valid_o <= valid_d;
      evt_id_o    <= id_d;
      lg_q        <= lg_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_OFFER;
      ST_OFFER: if (hs && !pick_any) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    valid_d = evt_valid_o;
    id_d    = evt_id_o;
    lg_d    = lg_q;
    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (pick_any) begin
          valid_d = 1'b1;
          id_d    = pick_id;
        end
      end
      ST_OFFER: begin
        valid_d = 1'b1;
        if (hs) begin
          lg_d = evt_id_o;
          if (pick_any) id_d = pick_id;
          else          valid_d = 1'b0;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

endmodule
